// File: rtl/phr_crc_tx_pkg.sv
// Shared constants, CRC FSM state type and the reflected CRC-16 bit step
// used by the phr_crc_tx framing block.
package phr_crc_tx_pkg;

    localparam logic [15:0] CRC_POLY_REFL    = 16'h8408;
    localparam logic [15:0] CRC_INIT_DEFAULT = 16'h0000;
    localparam int          PHR_BITS         = 8;
    localparam int          FCS_BITS         = 16;

    typedef enum logic [1:0] {
        CRC_IDLE = 2'd0,
        CRC_PHR  = 2'd1,
        CRC_PSDU = 2'd2,
        CRC_FCS  = 2'd3
    } crc_state_e;

    // One LSB-first bit through the reflected x^16+x^12+x^5+1 register.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic [15:0] nxt;
        nxt = crc >> 1;
        if (b ^ crc[0]) begin
            nxt = nxt ^ CRC_POLY_REFL;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/phr_crc_tx_byte_serializer_fifo.sv
// Byte FIFO feeding an LSB-first serializer; emits one registered bit per clock
// and pops the next byte straight after bit 7 so back-to-back bytes are gap-free.
module byte_serializer_fifo
    import phr_crc_tx_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       fifo_output,
    output logic       fifo_output_valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [6:0]       shreg;
    logic [2:0]       bit_idx;

    logic full;
    logic empty;
    logic do_wr;
    logic do_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_valid && !full;
    // A new byte is taken when nothing is shifting or the last bit is on the wire.
    assign do_rd = (!fifo_output_valid || (bit_idx == 3'd7)) && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            shreg             <= '0;
            bit_idx           <= '0;
            fifo_output       <= 1'b0;
            fifo_output_valid <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (do_rd) begin
                fifo_output       <= mem[rd_ptr][0];
                shreg             <= mem[rd_ptr][7:1];
                bit_idx           <= 3'd0;
                fifo_output_valid <= 1'b1;
            end else if (fifo_output_valid && (bit_idx != 3'd7)) begin
                fifo_output <= shreg[0];
                shreg       <= {1'b0, shreg[6:1]};
                bit_idx     <= bit_idx + 1'b1;
            end else begin
                fifo_output       <= 1'b0;
                fifo_output_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/phr_crc_tx.sv
// 802.15.4-style transmit framer: passes PHR and PSDU bits through one register
// stage and appends the reflected CRC-16 (KERMIT) FCS computed over the PSDU.
module phr_crc_tx
    import phr_crc_tx_pkg::*;
#(
    parameter int          DEPTH    = 128,
    parameter logic [15:0] CRC_INIT = CRC_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] phr_psdu_in,
    input  logic       phr_psdu_in_valid,
    output logic       tx_out,
    output logic       tx_out_valid
);

    // Handshake: the serializer presents a bit whenever fifo_output_valid is high;
    // there is no back-pressure, every presented bit is consumed on that edge.
    logic       fifo_output;
    logic       fifo_output_valid;

    crc_state_e  state;
    logic [4:0]  bit_cnt;
    logic [15:0] crc;

    byte_serializer_fifo #(
        .DEPTH(DEPTH)
    ) u_ser (
        .clk               (clk),
        .rst               (reset_n),
        .wr_data           (phr_psdu_in),
        .wr_valid          (phr_psdu_in_valid),
        .fifo_output       (fifo_output),
        .fifo_output_valid (fifo_output_valid)
    );

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state        <= CRC_IDLE;
            bit_cnt      <= '0;
            crc          <= CRC_INIT;
            tx_out       <= 1'b0;
            tx_out_valid <= 1'b0;
        end else begin
            case (state)
                CRC_IDLE: begin
                    crc          <= CRC_INIT;
                    tx_out       <= 1'b0;
                    tx_out_valid <= 1'b0;
                    if (fifo_output_valid) begin
                        tx_out       <= fifo_output;
                        tx_out_valid <= 1'b1;
                        bit_cnt      <= 5'd1;
                        state        <= CRC_PHR;
                    end
                end
                CRC_PHR: begin
                    if (fifo_output_valid) begin
                        tx_out       <= fifo_output;
                        tx_out_valid <= 1'b1;
                        bit_cnt      <= bit_cnt + 1'b1;
                        if (bit_cnt == 5'(PHR_BITS - 1)) begin
                            state <= CRC_PSDU;
                        end
                    end else begin
                        // Truncated header: abandon the frame, no FCS.
                        tx_out       <= 1'b0;
                        tx_out_valid <= 1'b0;
                        crc          <= CRC_INIT;
                        state        <= CRC_IDLE;
                    end
                end
                CRC_PSDU: begin
                    tx_out_valid <= 1'b1;
                    if (fifo_output_valid) begin
                        tx_out <= fifo_output;
                        crc    <= crc_step(crc, fifo_output);
                    end else begin
                        // FIFO ran dry: FCS bit0 follows the last PSDU bit directly.
                        tx_out  <= crc[0];
                        crc     <= crc >> 1;
                        bit_cnt <= 5'd1;
                        state   <= CRC_FCS;
                    end
                end
                CRC_FCS: begin
                    if (bit_cnt == 5'(FCS_BITS)) begin
                        tx_out       <= 1'b0;
                        tx_out_valid <= 1'b0;
                        crc          <= CRC_INIT;
                        state        <= CRC_IDLE;
                    end else begin
                        tx_out       <= crc[0];
                        tx_out_valid <= 1'b1;
                        crc          <= crc >> 1;
                        bit_cnt      <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_out       <= 1'b0;
                    tx_out_valid <= 1'b0;
                    state        <= CRC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phr_crc_tx.sv
// Directed bench for phr_crc_tx: a default-depth and a shallow instance share the
// input bursts, and a frame-level model predicts every output cycle of both.
module tb_phr_crc_tx;

  localparam int DEPTH_BIG   = 128;
  localparam int DEPTH_SMALL = 8;

  typedef struct {
    int   cyc;
    logic b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       vin = 1'b0;
  logic       tx_big, txv_big, tx_small, txv_small;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   last_end = 0;
  exp_t exp_big_q[$];
  exp_t exp_small_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  phr_crc_tx #(.DEPTH(DEPTH_BIG)) dut_big (
    .clk               (clk),
    .reset_n           (rst),
    .phr_psdu_in       (din),
    .phr_psdu_in_valid (vin),
    .tx_out            (tx_big),
    .tx_out_valid      (txv_big)
  );

  phr_crc_tx #(.DEPTH(DEPTH_SMALL)) dut_small (
    .clk               (clk),
    .reset_n           (rst),
    .phr_psdu_in       (din),
    .phr_psdu_in_valid (vin),
    .tx_out            (tx_small),
    .tx_out_valid      (txv_small)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [15:0] crc16_model(input logic [7:0] bytes[$], input int first);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = first; i < bytes.size(); i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = bytes[i][k] ^ c[0];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  // Bursts drain one byte per 8 cycles starting the edge after the first write;
  // a byte is accepted only if the FIFO holds fewer than depth bytes before its edge.
  function automatic void accept_bytes(input int depth, input logic [7:0] burst[$],
                                       output logic [7:0] acc[$]);
    int drained;
    acc = {};
    for (int j = 0; j < burst.size(); j++) begin
      drained = (j >= 2) ? ((j - 2) / 8 + 1) : 0;
      if (acc.size() - drained < depth) acc.push_back(burst[j]);
    end
  endfunction

  function automatic void frame_bits(input logic [7:0] acc[$], output logic bits[$]);
    logic [15:0] fcs;
    bits = {};
    foreach (acc[i]) for (int k = 0; k < 8; k++) bits.push_back(acc[i][k]);
    fcs = crc16_model(acc, 1);
    for (int k = 0; k < 16; k++) bits.push_back(fcs[k]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_burst(input logic [7:0] burst[$]);
    logic [7:0] acc_b[$];
    logic [7:0] acc_s[$];
    logic       bits_b[$];
    logic       bits_s[$];
    int         start;
    @(negedge clk);
    start = cyc + 3;
    accept_bytes(DEPTH_BIG, burst, acc_b);
    accept_bytes(DEPTH_SMALL, burst, acc_s);
    frame_bits(acc_b, bits_b);
    frame_bits(acc_s, bits_s);
    foreach (bits_b[i]) exp_big_q.push_back('{start + i, bits_b[i]});
    foreach (bits_s[i]) exp_small_q.push_back('{start + i, bits_s[i]});
    last_end = start + ((bits_b.size() > bits_s.size()) ? bits_b.size() : bits_s.size());
    foreach (burst[j]) begin
      din = burst[j];
      vin = 1'b1;
      @(negedge clk);
    end
    din = 8'h00;
    vin = 1'b0;
  endtask

  task automatic wait_drain();
    while (cyc <= last_end + 20) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_big_valid"}, txv_big, 1'b0);
    check({tag, "_big_out"}, tx_big, 1'b0);
    check({tag, "_small_valid"}, txv_small, 1'b0);
    check({tag, "_small_out"}, tx_small, 1'b0);
    exp_big_q.delete();
    exp_small_q.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic ev, eb;
    ev = 1'b0;
    eb = 1'b0;
    if (exp_big_q.size() > 0 && exp_big_q[0].cyc == cyc) begin
      ev = 1'b1;
      eb = exp_big_q[0].b;
      void'(exp_big_q.pop_front());
    end
    check("big_valid", txv_big, ev);
    check("big_bit", tx_big, eb);
    ev = 1'b0;
    eb = 1'b0;
    if (exp_small_q.size() > 0 && exp_small_q[0].cyc == cyc) begin
      ev = 1'b1;
      eb = exp_small_q[0].b;
      void'(exp_small_q.pop_front());
    end
    check("small_valid", txv_small, ev);
    check("small_bit", tx_small, eb);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  b[$];
    logic [7:0]  acc[$];
    logic        bits[$];
    logic [31:0] pat;

    // Hand-computed values that pin the model itself.
    b = '{8'h01};
    check("pin_crc_01", crc16_model(b, 0), 16'h1189);
    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("pin_crc_123456789", crc16_model(b, 0), 16'h2189);
    b = '{8'h00};
    check("pin_crc_00", crc16_model(b, 0), 16'h0000);
    b = '{8'h03, 8'h01};
    frame_bits(b, bits);
    pat = '0;
    foreach (bits[i]) pat[31 - i] = bits[i];
    check("pin_frame_bits", pat, 32'b11000000_10000000_10010001_10001000);
    check("pin_frame_len", bits.size(), 32);
    b = '{8'h0B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    accept_bytes(8, b, acc);
    check("pin_accept_depth8", acc.size(), 9);

    #1 rst = 1'b1;
    #3;
    check("init_rst_valid", txv_big, 1'b0);
    check("init_rst_out", tx_big, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);

    do_reset("rst_idle");
    repeat (5) @(negedge clk);

    b = '{8'h03, 8'h01};
    send_burst(b);
    wait_drain();

    b = '{8'h0B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_burst(b);
    wait_drain();

    b = '{8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87};
    send_burst(b);
    wait_drain();

    b = '{8'h02, 8'h00};
    send_burst(b);
    wait_drain();
    send_burst(b);
    wait_drain();

    // Abort a frame in its PSDU, then confirm silence and a clean next frame.
    b = '{8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87};
    send_burst(b);
    repeat (30) @(negedge clk);
    do_reset("rst_frame");
    repeat (40) @(negedge clk);
    b = '{8'h03, 8'h01};
    send_burst(b);
    wait_drain();

    b = {};
    for (int j = 0; j < 129; j++) b.push_back(8'((j * 37 + 11) & 8'hFF));
    send_burst(b);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
